// File: rtl/servant_mux_pkg.sv
// servant_mux_pkg
// Shared definitions for the servant data-bus interconnect (servant_mux_n).
//   state_t     : FSM state encoding (IDLE=0, BUSY=1, RESP=2)
//   MAX_SLAVES  : upper bound on the number of targets
//   SLICE_W     : width of one slave read-data slice
package servant_mux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int MAX_SLAVES = 16;
    localparam int SLICE_W    = 32;

endpackage

// File: rtl/servant_mux_wdt.sv
// servant_mux_wdt
// Hang watchdog for servant_mux_n. The whole module exists only when the
// macro SERVANT_MUX_TIMEOUT_EN is defined, matching the single instance in
// the top, so a default build carries no dangling module.
// Ports:
//   i_clk      in   system clock
//   i_rst      in   synchronous active-high reset
//   i_clr      in   clear counter to zero (held while no slave access is pending)
//   i_en       in   count one cycle (slave access pending)
//   o_expired  out  high in the TIMEOUT-th consecutive enabled cycle
`ifdef SERVANT_MUX_TIMEOUT_EN
module servant_mux_wdt #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            count <= '0;
        end else if (i_en) begin
            count <= count + CW'(1);
        end
    end

    // Count holds the number of enabled cycles already elapsed, so the
    // TIMEOUT-th enabled cycle is the one where it equals TIMEOUT-1. The
    // owner leaves the enabled state on expiry, so the counter never wraps.
    assign o_expired = i_en && (count == CW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/servant_mux_n.sv
// servant_mux_n
// Wishbone-classic data-bus fan-out: one CPU dbus master to NUM_SLAVES
// targets selected by the top SEL_BITS address bits. Slave-side request
// signals and the CPU response are all registered. Unmapped indices are
// acknowledged immediately (writes dropped, reads return zero).
// Optional feature: define SERVANT_MUX_TIMEOUT_EN to add a watchdog that
// forces a response carrying ERR_RDT after TIMEOUT cycles without a slave ack.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_wb_cpu_adr/dat/sel/we/cyc  master request
//   o_wb_cpu_rdt, o_wb_cpu_ack   master response (ack is a one-cycle pulse)
//   o_wb_s_adr/dat/sel/we        registered request shared by all slaves
//   o_wb_s_cyc                   one-hot slave strobe
//   i_wb_s_rdt, i_wb_s_ack       slave responses, slave k at rdt[32k+31:32k]
module servant_mux_n
    import servant_mux_pkg::*;
#(
    parameter int          NUM_SLAVES = 3,
    parameter int          SEL_BITS   = 2,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_RDT    = 32'hDEADBEEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [31:0]                   i_wb_cpu_adr,
    input  logic [31:0]                   i_wb_cpu_dat,
    input  logic [3:0]                    i_wb_cpu_sel,
    input  logic                          i_wb_cpu_we,
    input  logic                          i_wb_cpu_cyc,
    output logic [31:0]                   o_wb_cpu_rdt,
    output logic                          o_wb_cpu_ack,
    output logic [31:0]                   o_wb_s_adr,
    output logic [31:0]                   o_wb_s_dat,
    output logic [3:0]                    o_wb_s_sel,
    output logic                          o_wb_s_we,
    output logic [NUM_SLAVES-1:0]         o_wb_s_cyc,
    input  logic [SLICE_W*NUM_SLAVES-1:0] i_wb_s_rdt,
    input  logic [NUM_SLAVES-1:0]         i_wb_s_ack
);

    state_t state;

    // Address decode (combinational, consumed only in IDLE)
    logic [SEL_BITS-1:0]   idx;
    logic                  mapped;
    logic [NUM_SLAVES-1:0] dec;

    assign idx    = i_wb_cpu_adr[31 -: SEL_BITS];
    assign mapped = (int'(idx) < NUM_SLAVES);

    always_comb begin
        dec = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            dec[k] = (int'(idx) == k);
        end
    end

    // Response select: the registered one-hot strobe doubles as the mux
    // select, so acks and data from non-selected slaves are masked out.
    logic [SLICE_W-1:0] rdt_mux;
    logic               ack_hit;

    always_comb begin
        rdt_mux = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (o_wb_s_cyc[k]) begin
                rdt_mux = rdt_mux | i_wb_s_rdt[SLICE_W*k +: SLICE_W];
            end
        end
        ack_hit = |(i_wb_s_ack & o_wb_s_cyc);
    end

`ifdef SERVANT_MUX_TIMEOUT_EN
    logic expired;

    servant_mux_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (state != BUSY),
        .i_en      (state == BUSY),
        .o_expired (expired)
    );
`else
    // Timeout parameters have no function without the watchdog.
    logic [31:0] unused_cfg;
    assign unused_cfg = ERR_RDT ^ 32'(TIMEOUT);
`endif

    // Control FSM with registered slave request and CPU response
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            o_wb_s_cyc   <= '0;
            o_wb_cpu_ack <= 1'b0;
            o_wb_cpu_rdt <= '0;
            o_wb_s_adr   <= '0;
            o_wb_s_dat   <= '0;
            o_wb_s_sel   <= '0;
            o_wb_s_we    <= 1'b0;
        end else begin
            o_wb_cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_wb_cpu_cyc) begin
                        if (mapped) begin
                            o_wb_s_adr <= i_wb_cpu_adr;
                            o_wb_s_dat <= i_wb_cpu_dat;
                            o_wb_s_sel <= i_wb_cpu_sel;
                            o_wb_s_we  <= i_wb_cpu_we;
                            o_wb_s_cyc <= dec;
                            state      <= BUSY;
                        end else begin
                            // Unmapped: answer at once without touching any slave.
                            o_wb_cpu_rdt <= '0;
                            o_wb_cpu_ack <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end
                BUSY: begin
                    if (!i_wb_cpu_cyc) begin
                        // Master abandoned the access: release the slave, no ack.
                        o_wb_s_cyc <= '0;
                        state      <= IDLE;
                    end else if (ack_hit) begin
                        // A real ack takes priority over a simultaneous timeout.
                        o_wb_cpu_rdt <= rdt_mux;
                        o_wb_cpu_ack <= 1'b1;
                        o_wb_s_cyc   <= '0;
                        state        <= RESP;
`ifdef SERVANT_MUX_TIMEOUT_EN
                    end else if (expired) begin
                        o_wb_cpu_rdt <= ERR_RDT;
                        o_wb_cpu_ack <= 1'b1;
                        o_wb_s_cyc   <= '0;
                        state        <= RESP;
`endif
                    end
                end
                RESP: begin
                    // Ack is visible this cycle; the request is ignored until IDLE.
                    state <= IDLE;
                end
                default: begin
                    o_wb_s_cyc <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servant_mux_n.sv
// tb_servant_mux_n
// Randomized bench for servant_mux_n. The bench plays both the CPU master and
// the slaves. Each transaction's expected behaviour (strobe window, ack cycle,
// returned data) is computed up front from the bus rules; the DUT is then
// compared cycle by cycle. Build with SERVANT_MUX_TIMEOUT_EN to cover timeouts.
module tb_servant_mux_n;

    localparam int          NS  = 3;
    localparam int          SB  = 2;
    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       cpu_adr, cpu_dat;
    logic [3:0]        cpu_sel;
    logic              cpu_we, cpu_cyc;
    logic [31:0]       cpu_rdt;
    logic              cpu_ack;
    logic [31:0]       s_adr, s_dat;
    logic [3:0]        s_sel;
    logic              s_we;
    logic [NS-1:0]     s_cyc;
    logic [32*NS-1:0]  s_rdt;
    logic [NS-1:0]     s_ack;

    always #5 clk = ~clk;

    servant_mux_n #(
        .NUM_SLAVES (NS),
        .SEL_BITS   (SB),
        .TIMEOUT    (TO),
        .ERR_RDT    (ERR)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wb_cpu_adr (cpu_adr),
        .i_wb_cpu_dat (cpu_dat),
        .i_wb_cpu_sel (cpu_sel),
        .i_wb_cpu_we  (cpu_we),
        .i_wb_cpu_cyc (cpu_cyc),
        .o_wb_cpu_rdt (cpu_rdt),
        .o_wb_cpu_ack (cpu_ack),
        .o_wb_s_adr   (s_adr),
        .o_wb_s_dat   (s_dat),
        .o_wb_s_sel   (s_sel),
        .o_wb_s_we    (s_we),
        .o_wb_s_cyc   (s_cyc),
        .i_wb_s_rdt   (s_rdt),
        .i_wb_s_ack   (s_ack)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] last_rdt = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    task automatic rand_rdt();
        for (int k = 0; k < NS; k++) s_rdt[32*k +: 32] = $urandom;
    endtask

    // One idle cycle with cyc low and random stray slave acks.
    task automatic idle_cycle();
        cpu_cyc = 1'b0;
        s_ack   = NS'($urandom);
        rand_rdt();
        @(negedge clk);
        chk("idle_ack", 32'(cpu_ack), 32'h0);
        chk("idle_scyc", 32'(s_cyc), 32'h0);
        chk("idle_rdt", cpu_rdt, last_rdt);
    endtask

    // Full transaction. Entered at the negedge of an IDLE cycle (cycle 0),
    // returns at the negedge of the cycle after the cpu ack. Slave answers
    // d cycles after its strobe first appears (ack in cycle 1+d).
    task automatic txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                       input logic [3:0] sel, input int d,
                       input bit use_fdat, input logic [31:0] fdat);
        int            k;
        bit            mapped;
        bit            timed;
        int            strobe_end;
        int            exp_t;
        logic [31:0]   exp_rdt;
        logic [NS-1:0] oh;
        logic [NS-1:0] exp_scyc;
        k        = int'(adr[31:32-SB]);
        mapped   = (k < NS);
        timed    = 1'b0;
        oh       = mapped ? (NS'(1) << k) : '0;
        exp_rdt  = 32'h0;
        strobe_end = mapped ? 1 + d : 0;
        exp_t    = mapped ? 2 + d : 1;
`ifdef SERVANT_MUX_TIMEOUT_EN
        if (mapped && d >= TO) begin
            timed      = 1'b1;
            strobe_end = TO;
            exp_t      = TO + 1;
            exp_rdt    = ERR;
        end
`endif
        cpu_adr = adr; cpu_dat = dat; cpu_sel = sel; cpu_we = we; cpu_cyc = 1'b1;
        s_ack   = NS'($urandom) & ~oh;
        rand_rdt();
        for (int t = 1; t <= exp_t; t++) begin
            @(negedge clk);
            exp_scyc = (mapped && t <= strobe_end) ? oh : '0;
            chk("s_cyc", 32'(s_cyc), 32'(exp_scyc));
            chk("cpu_ack", 32'(cpu_ack), 32'(t == exp_t));
            if (t == exp_t) begin
                chk("cpu_rdt", cpu_rdt, exp_rdt);
                last_rdt = exp_rdt;
            end else begin
                chk("rdt_hold", cpu_rdt, last_rdt);
            end
            if (exp_scyc != '0) begin
                chk("s_adr", s_adr, adr);
                chk("s_dat", s_dat, dat);
                chk("s_sel", 32'(s_sel), 32'(sel));
                chk("s_we", 32'(s_we), 32'(we));
            end
            rand_rdt();
            s_ack = NS'($urandom) & ~oh;
            if (mapped && !timed && t == 1 + d) begin
                if (use_fdat) s_rdt[32*k +: 32] = fdat;
                exp_rdt = s_rdt[32*k +: 32];
                s_ack   = s_ack | oh;
            end
        end
        // Master keeps cyc through the ack cycle; a second ack must not follow.
        @(negedge clk);
        chk("no_2nd_ack", 32'(cpu_ack), 32'h0);
        chk("post_scyc", 32'(s_cyc), 32'h0);
        chk("post_rdt", cpu_rdt, last_rdt);
    endtask

    task automatic abort_txn(input int k);
        logic [NS-1:0] oh;
        oh = NS'(1) << k;
        cpu_adr = {2'(k), 30'($urandom)}; cpu_we = 1'b0; cpu_cyc = 1'b1;
        s_ack = '0;
        @(negedge clk);
        chk("abort_scyc1", 32'(s_cyc), 32'(oh));
        @(negedge clk);
        chk("abort_scyc2", 32'(s_cyc), 32'(oh));
        cpu_cyc = 1'b0;
        @(negedge clk);
        chk("abort_scyc3", 32'(s_cyc), 32'h0);
        chk("abort_ack3", 32'(cpu_ack), 32'h0);
        s_ack = oh;  // late ack after the abort must be ignored
        @(negedge clk);
        chk("abort_ack4", 32'(cpu_ack), 32'h0);
        chk("abort_scyc4", 32'(s_cyc), 32'h0);
        s_ack = '0;
    endtask

    task automatic reset_txn(input int k);
        logic [NS-1:0] oh;
        oh = NS'(1) << k;
        cpu_adr = {2'(k), 30'($urandom)}; cpu_dat = $urandom; cpu_sel = 4'hF;
        cpu_we = 1'b1; cpu_cyc = 1'b1; s_ack = '0;
        @(negedge clk);
        chk("rst_scyc1", 32'(s_cyc), 32'(oh));
        @(negedge clk);
        chk("rst_scyc2", 32'(s_cyc), 32'(oh));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_scyc", 32'(s_cyc), 32'h0);
        chk("rst_mid_ack", 32'(cpu_ack), 32'h0);
        chk("rst_mid_rdt", cpu_rdt, 32'h0);
        chk("rst_mid_adr", s_adr, 32'h0);
        chk("rst_mid_dat", s_dat, 32'h0);
        chk("rst_mid_sel", 32'(s_sel), 32'h0);
        chk("rst_mid_we", 32'(s_we), 32'h0);
        last_rdt = 32'h0;
        rst = 1'b0; cpu_cyc = 1'b0; s_ack = oh;
        @(negedge clk);
        chk("rst_after_ack", 32'(cpu_ack), 32'h0);
        chk("rst_after_scyc", 32'(s_cyc), 32'h0);
        s_ack = '0;
    endtask

    initial begin
        rst = 1'b1; cpu_cyc = 1'b0; cpu_adr = '0; cpu_dat = '0; cpu_sel = '0;
        cpu_we = 1'b0; s_ack = '0; s_rdt = '0;
        repeat (2) @(negedge clk);
        chk("reset_ack", 32'(cpu_ack), 32'h0);
        chk("reset_rdt", cpu_rdt, 32'h0);
        chk("reset_scyc", 32'(s_cyc), 32'h0);
        chk("reset_adr", s_adr, 32'h0);
        chk("reset_dat", s_dat, 32'h0);
        chk("reset_sel", 32'(s_sel), 32'h0);
        chk("reset_we", 32'(s_we), 32'h0);
        rst = 1'b0;
        idle_cycle();

        // Directed cases from the block description
        txn(32'h4000_0010, 1'b0, 32'h0, 4'hF, 2, 1'b1, 32'h1234_5678);
        txn(32'h0000_0004, 1'b1, 32'hA5A5_A5A5, 4'b0011, 1, 1'b0, 32'h0);
        txn(32'hC000_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h0);
        txn(32'h0000_0100, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h0);
        txn(32'h8000_0200, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h0);
        txn(32'h8000_0040, 1'b0, 32'h0, 4'hF, TO - 1, 1'b1, 32'hCAFE_F00D);
        txn(32'h8000_0044, 1'b0, 32'h0, 4'hF, TO, 1'b0, 32'h0);
        txn(32'h4000_0048, 1'b1, 32'h1, 4'h1, 20, 1'b0, 32'h0);
        abort_txn(1);
        idle_cycle();
        reset_txn(2);
        idle_cycle();

        // Random traffic, including unmapped and occasional long waits
        for (int n = 0; n < 300; n++) begin
            int d;
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 12) : $urandom_range(0, 3);
            txn($urandom, 1'($urandom), $urandom, 4'($urandom), d, 1'b0, 32'h0);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
